// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } seq_state_t;

  localparam int CNT_W = 16;
  localparam int LLC_W = 8;
  localparam logic [LLC_W-1:0] LLC_MAX = {LLC_W{1'b1}};

endpackage

// File: rtl/pll_rst_seq_sync2.sv
// Two-flop synchronizer for asynchronous PLL status inputs; clears to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset / lock-qualification sequencer gating the core reset.
//
// state     | meaning
// RST_PLL   | pll_reset held high for PLL_RST_CYC cycles
// WAIT_LOCK | pll_reset released, waiting up to LOCK_TIMEOUT for lock
// STABLE    | lock seen, must hold LOCK_STABLE_CYC consecutive cycles
// RUN       | core released; any lock loss re-sequences
// FAIL      | retries exhausted; left only via reset or reinit_req
module pll_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYC     = 16,
  parameter int LOCK_TIMEOUT    = 1024,
  parameter int LOCK_STABLE_CYC = 64,
  parameter int MAX_RETRY       = 3,
  parameter bit LOCK_BYPASS     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             extlock,
  input  logic             stdby,
  input  logic             reinit_req,
  output logic             pll_reset,
  output logic             core_rst_n,
  output logic             pll_ready,
  output logic             lock_err,
  output logic [1:0]       retry_cnt,
  output logic [LLC_W-1:0] lost_lock_cnt
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [1:0]       RETRY_MX = 2'(MAX_RETRY);

  logic lock_s, stdby_s, lock_q;

  sync2 u_sync_lock  (.clk(clk), .reset(reset), .d(extlock), .q(lock_s));
  sync2 u_sync_stdby (.clk(clk), .reset(reset), .d(stdby),   .q(stdby_s));

  assign lock_q = LOCK_BYPASS ? 1'b1 : (lock_s & ~stdby_s);

  seq_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             cnt_clr;
  logic [1:0]       retry_nx;
  logic             err_nx;
  logic [LLC_W-1:0] llc_nx;

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    retry_nx = retry_cnt;
    err_nx   = lock_err;
    llc_nx   = lost_lock_cnt;

    case (state)
      RST_PLL: begin
        if (cnt == RST_LAST) state_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock arriving on the timeout cycle takes precedence over the retry.
        if (lock_q) begin
          state_nx = STABLE;
        end else if (cnt == TMO_LAST) begin
          if (retry_cnt == RETRY_MX) begin
            state_nx = FAIL;
            err_nx   = 1'b1;
          end else begin
            state_nx = RST_PLL;
            retry_nx = retry_cnt + 2'd1;
          end
        end
      end
      STABLE: begin
        if (!lock_q)                state_nx = WAIT_LOCK;
        else if (cnt == STB_LAST)   state_nx = RUN;
      end
      RUN: begin
        if (!lock_q) begin
          state_nx = RST_PLL;
          retry_nx = 2'd0;
          if (lost_lock_cnt != LLC_MAX) llc_nx = lost_lock_cnt + 1'b1;
        end
      end
      FAIL: begin
        state_nx = FAIL;
      end
      default: begin
        state_nx = RST_PLL;
      end
    endcase

    // A restart request overrides everything but keeps the lock-loss history.
    if (reinit_req) begin
      state_nx = RST_PLL;
      cnt_clr  = 1'b1;
      retry_nx = 2'd0;
      err_nx   = 1'b0;
      llc_nx   = lost_lock_cnt;
    end

    if (cnt_clr || (state_nx != state))        cnt_nx = '0;
    else if ((state == RUN) || (state == FAIL)) cnt_nx = cnt;
    else                                       cnt_nx = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RST_PLL;
      cnt           <= '0;
      pll_reset     <= 1'b1;
      core_rst_n    <= 1'b0;
      pll_ready     <= 1'b0;
      lock_err      <= 1'b0;
      retry_cnt     <= 2'd0;
      lost_lock_cnt <= '0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      pll_reset     <= (state_nx == RST_PLL) || (state_nx == FAIL);
      core_rst_n    <= (state_nx == RUN);
      pll_ready     <= (state_nx == RUN);
      lock_err      <= err_nx;
      retry_cnt     <= retry_nx;
      lost_lock_cnt <= llc_nx;
    end
  end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: table rows, hand-written corner sequences and a random run against a phase model.
module tb_pll_rst_seq;

  localparam int TP = 4;
  localparam int TT = 32;
  localparam int TS = 8;
  localparam int TR = 3;

  logic clk;
  logic reset, reinit_req;
  logic ext_t, stdby_t, ext_d, ext_b;

  logic       pr_t, cr_t, rdy_t, err_t;
  logic [1:0] rt_t;
  logic [7:0] llc_t;
  logic       pr_b, cr_b, rdy_b, err_b;
  logic [1:0] rt_b;
  logic [7:0] llc_b;
  logic       pr_d, cr_d, rdy_d, err_d;
  logic [1:0] rt_d;
  logic [7:0] llc_d;

  int n_tests = 0;
  int n_fail  = 0;

  pll_rst_seq #(.PLL_RST_CYC(TP), .LOCK_TIMEOUT(TT), .LOCK_STABLE_CYC(TS),
                .MAX_RETRY(TR), .LOCK_BYPASS(1'b0)) u_tmo (
    .clk(clk), .reset(reset), .extlock(ext_t), .stdby(stdby_t), .reinit_req(reinit_req),
    .pll_reset(pr_t), .core_rst_n(cr_t), .pll_ready(rdy_t), .lock_err(err_t),
    .retry_cnt(rt_t), .lost_lock_cnt(llc_t));

  pll_rst_seq #(.PLL_RST_CYC(TP), .LOCK_TIMEOUT(TT), .LOCK_STABLE_CYC(TS),
                .MAX_RETRY(TR), .LOCK_BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .extlock(ext_b), .stdby(1'b0), .reinit_req(reinit_req),
    .pll_reset(pr_b), .core_rst_n(cr_b), .pll_ready(rdy_b), .lock_err(err_b),
    .retry_cnt(rt_b), .lost_lock_cnt(llc_b));

  pll_rst_seq u_def (
    .clk(clk), .reset(reset), .extlock(ext_d), .stdby(1'b0), .reinit_req(reinit_req),
    .pll_reset(pr_d), .core_rst_n(cr_d), .pll_ready(rdy_d), .lock_err(err_d),
    .retry_cnt(rt_d), .lost_lock_cnt(llc_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Phase model: 0 reset pulse, 1 waiting for lock, 2 qualifying, 3 running, 4 failed.
  int m_ph, m_el, m_retry, m_llc;
  bit m_err;
  bit lk_hist[$];

  task automatic m_enter(input int ph);
    m_ph = ph;
    m_el = 0;
  endtask

  task automatic model_step(input bit r, input bit q, input bit e, input bit s);
    bit lq;
    if (r) begin
      m_enter(0); m_retry = 0; m_llc = 0; m_err = 0;
      lk_hist = '{1'b0, 1'b0};
      return;
    end
    // The lock decision at this edge uses the input seen two edges earlier.
    lq = LOCK_HIST_POP();
    lk_hist.push_back(e & ~s);
    if (q) begin
      m_enter(0); m_retry = 0; m_err = 0;
      return;
    end
    m_el++;
    case (m_ph)
      0: if (m_el == TP) m_enter(1);
      1: begin
        if (lq) m_enter(2);
        else if (m_el == TT) begin
          if (m_retry == TR) begin m_enter(4); m_err = 1; end
          else begin m_retry++; m_enter(0); end
        end
      end
      2: begin
        if (!lq) m_enter(1);
        else if (m_el == TS) m_enter(3);
      end
      3: begin
        if (!lq) begin
          if (m_llc < 255) m_llc++;
          m_retry = 0;
          m_enter(0);
        end
      end
      default: ;
    endcase
  endtask

  function automatic bit LOCK_HIST_POP();
    return lk_hist.pop_front();
  endfunction

  function automatic logic [13:0] mvec();
    logic [1:0] rt;
    logic [7:0] ll;
    rt = 2'(m_retry);
    ll = 8'(m_llc);
    return {(m_ph == 0) || (m_ph == 4), m_ph == 3, m_ph == 3, m_err, rt, ll};
  endfunction

  function automatic logic [13:0] tvec();
    return {pr_t, cr_t, rdy_t, err_t, rt_t, llc_t};
  endfunction

  task automatic step_t(input bit r, input bit q, input bit e, input bit s);
    reset = r; reinit_req = q; ext_t = e; stdby_t = s;
    model_step(r, q, e, s);
    @(posedge clk); #1;
    chk("model", 32'(tvec()), 32'(mvec()));
  endtask

  typedef struct {
    bit rst, rq, ext, sb;
    int n;
    logic [13:0] exp;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(input bit rst, rq, ext, sb, input int n,
                              input bit pr, cr, rdy, err, input int rt, input int llc);
    row_t x;
    x.rst = rst; x.rq = rq; x.ext = ext; x.sb = sb; x.n = n;
    x.exp = {pr, cr, rdy, err, 2'(rt), 8'(llc)};
    return x;
  endfunction

  bit re, rs;
  int rlen;

  initial begin
    reset = 1'b1; reinit_req = 1'b0; ext_t = 1'b0; stdby_t = 1'b0; ext_d = 1'b0; ext_b = 1'b0;
    m_ph = 0; m_el = 0; m_retry = 0; m_llc = 0; m_err = 0;
    lk_hist = '{1'b0, 1'b0};

    //            rst rq ext sb  n    pr cr rdy err rt llc
    tbl.push_back(mk(1, 0, 0, 0,  2,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  4,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32,  1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 36,  1, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 36,  1, 0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 35,  0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1,  1, 0, 0, 1, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 20,  1, 0, 0, 1, 3, 0));
    tbl.push_back(mk(0, 1, 1, 0,  1,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  3,  1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  8,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,  1,  0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 10,  0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  2,  0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  1,  1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 13,  0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1,  3,  1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 13,  0, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 1, 0,  1,  1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 13,  0, 1, 1, 0, 0, 2));
    tbl.push_back(mk(1, 0, 1, 0,  1,  1, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) step_t(tbl[i].rst, tbl[i].rq, tbl[i].ext, tbl[i].sb);
      chk($sformatf("row%0d", i), 32'(tvec()), 32'(tbl[i].exp));
    end

    // Bypass release latency: cycle 0 is the first cycle with reset low.
    step_t(1, 0, 0, 0);
    chk("byp_c0", {pr_b, cr_b, rdy_b}, 3'b100);
    for (int k = 1; k <= 15; k++) begin
      step_t(0, 0, 0, 0);
      chk($sformatf("byp_c%0d", k), {pr_b, cr_b, rdy_b},
          {k < TP, k >= TP + 1 + TS, k >= TP + 1 + TS});
    end

    // Default params: one-cycle lock glitch 40 cycles into STABLE restarts qualification.
    ext_d = 1'b1;
    step_t(1, 0, 0, 0);
    for (int k = 1; k <= 125; k++) begin
      ext_d = (k == 58) ? 1'b0 : 1'b1;
      step_t(0, 0, 0, 0);
      if (k == 16)  chk("def_wait_c16", {pr_d, cr_d}, 2'b00);
      if (k == 81)  chk("def_norel_c81", cr_d, 1'b0);
      if (k == 124) chk("def_norel_c124", cr_d, 1'b0);
      if (k == 125) chk("def_rel_c125", {cr_d, rdy_d, rt_d, err_d}, 5'b11000);
    end
    ext_d = 1'b1;
    step_t(1, 0, 0, 0);
    for (int k = 1; k <= 40; k++) step_t(0, 0, 0, 0);
    step_t(1, 0, 0, 0);
    chk("def_rst_stable", {pr_d, cr_d, rdy_d, err_d, rt_d, llc_d}, 14'b1000_00_00000000);
    for (int k = 1; k <= 81; k++) begin
      step_t(0, 0, 0, 0);
      if (k == 80) chk("def_norel_c80", cr_d, 1'b0);
      if (k == 81) chk("def_rel_c81", cr_d, 1'b1);
    end

    // 300 lock losses in RUN, saturation, saturation with reinit, reset.
    step_t(1, 0, 1, 0);
    for (int k = 0; k < 13; k++) step_t(0, 0, 1, 0);
    chk("sat_run0", cr_t, 1'b1);
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 3; k++)  step_t(0, 0, 0, 0);
      for (int k = 0; k < 13; k++) step_t(0, 0, 1, 0);
    end
    chk("sat_255", {cr_t, llc_t}, 9'h1FF);
    step_t(0, 0, 0, 0);
    step_t(0, 0, 0, 0);
    step_t(0, 1, 0, 0);
    chk("sat_reinit", {cr_t, pr_t, llc_t}, 10'b01_11111111);
    step_t(1, 0, 0, 0);
    chk("sat_reset", 32'(tvec()), 32'({1'b1, 13'd0}));

    // Random run against the model.
    step_t(1, 0, 0, 0);
    for (int seg = 0; seg < 90; seg++) begin
      re = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 9) == 0);
      rlen = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(8, 90);
      for (int c = 0; c < rlen; c++)
        step_t($urandom_range(0, 599) == 0, $urandom_range(0, 149) == 0, re, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
